rv_muldiv_seq: RTL and testbench
================================

# rv_muldiv_seq

Iterative RV64M multiply/divide sequencer that reuses the shared 64-bit integer ALU instead of instantiating its own adder. It sits in the execute stage beside the ALU. While busy it owns the ALU operand and op-select mux and issues one add or subtract per cycle, implementing shift-add multiply and restoring divide. Sign handling, RISC-V divide-by-zero and overflow rules, and result selection are performed internally.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- kill_i  in  1  pipeline flush; aborts any operation in progress.
- funct3_i  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  64  rs1 value (multiplicand or dividend).
- op2_i  in  64  rs2 value (multiplier or divisor).
- busy_o  out  1  high from the cycle after start until DONE inclusive.
- done_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  64  final result; holds its value until the next start.
- alu_op1_o  out  64  ALU operand 1.
- alu_op2_o  out  64  ALU operand 2.
- alu_op_sel_o  out  4  ALU select: 0010 add, 0110 sub, 0000 when idle.
- alu_result_i  in  64  ALU result, combinational in the same cycle.

## Operation
- Internal registers: A (64), B (64), ACC (64), CNT (6), NEG_RES, NEG_A, NEG_B, op latch.
- Reset values: state IDLE. busy_o, done_o, result_o, alu_op1_o, alu_op2_o are all 0. alu_op_sel_o is 0000.
- Start in IDLE: latch funct3, A=op2_i, B=op1_i, ACC=0, CNT=0. Then:
  - NEG_B = op1 negative for MULH, MULHSU, DIV, REM.
  - NEG_A = op2 negative for MULH, DIV, REM.
  - NEG_RES: NEG_A^NEG_B for MULH, MULHSU, DIV; NEG_B for REM; 0 otherwise.
- Special cases go IDLE->DONE directly with no ALU use:
  - Divisor 0: quotient 0xFFFF_FFFF_FFFF_FFFF; remainder = op1.
  - DIV/REM with op1 = 0x8000_0000_0000_0000 and op2 = all-ones: quotient = op1, remainder = 0.
- State sequence: IDLE -> NEG_B -> NEG_A -> ITER (64 cycles) -> FIX -> DONE -> IDLE.
- NEG_B: if NEG_B, ALU sub 0-B and write the result to B; otherwise B is held and the ALU is driven add 0+0. NEG_A does the same for A.
- ITER multiply, using CNT 0..63:
  - If B[0]: ALU add ACC+A giving S. Carry C = (S < ACC), unsigned, computed locally.
  - Otherwise S=ACC and C=0.
  - {ACC,B} <= {C,S,B[63:1]}.
- ITER divide:
  - R = {ACC[62:0],B[63]}, M = ACC[63]. ALU sub R-A.
  - If M or !(R < A): ACC=alu_result_i and B={B[62:0],1}.
  - Otherwise ACC=R and B={B[62:0],0}.
- ITER exits when CNT==63. After ITER: MUL result=B (low word); MULH* result=ACC (high word); quotient=B; remainder=ACC.
- FIX:
  - If NEG_RES and the op is MULH or MULHSU: result = ~ACC + (B==0), computed locally.
  - If NEG_RES and the op is DIV or REM: ALU sub 0-word.
  - Otherwise the word passes through unchanged.
- DONE: result_o is updated and done_o=1 for one cycle.
- kill_i in any non-IDLE state: next state is IDLE. No done_o is issued, result_o is unchanged, and the ALU outputs return to their idle values.
- start_i while not in IDLE is ignored and is not queued.

## Timing
- Start is sampled at edge 0.
- Normal operation: NEG_B in cycle 1, NEG_A in cycle 2, ITER in cycles 3-66, FIX in cycle 67, done_o in cycle 68. Latency is fixed at 68 cycles for all ops, including MUL and unsigned ops.
- Special cases: done_o in cycle 1.
- A start_i sampled in the DONE cycle is ignored. The earliest back-to-back start is the cycle after done_o.
- busy_o is registered: it is high in cycles 1..68 and low in IDLE.
- ALU outputs are registered-state-derived combinational signals. The ALU result is consumed in the same cycle.
- Asynchronous reset mid-operation forces IDLE and the reset values immediately. No done_o is issued.

## Test plan
- MUL with op1=7, op2=6 -> done_o in cycle 68, result 42. Also check that alu_op_sel_o is 0010 during ITER.
- MULHU with op1=op2=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE. MULH with op1=-2, op2=3 -> result all-ones.
- DIV with op1=-7, op2=2 -> result -3. REM with the same operands -> result -1. DIVU with op1=100, op2=7 -> 14. REMU -> 2.
- DIVU with op2=0 -> done_o in cycle 1, result all-ones. REM with op1=0x8000_0000_0000_0000, op2=-1 -> result 0 in cycle 1.
- kill_i asserted in cycle 30 -> IDLE in cycle 31, no done_o, result_o unchanged. A new start_i in cycle 31 then completes normally.
- rst_n_i pulled low in cycle 40 -> busy_o=0 and alu_op_sel_o=0000 immediately. A start_i asserted while busy is ignored, confirmed by exactly one done_o.

Source files
------------

// File: rtl/rv_muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer that borrows the shared execute-stage ALU.
// Shift-add multiply and restoring divide, one ALU add/sub per cycle, fixed 68-cycle latency.
module rv_muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] alu_op1_o,
  output logic [XLEN-1:0] alu_op2_o,
  output logic [3:0]      alu_op_sel_o,
  input  logic [XLEN-1:0] alu_result_i
);

  localparam int CW = $clog2(XLEN);
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEGB,
    S_NEGA,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_res;
  logic            r_neg_a;
  logic            r_neg_b;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_s_mulh;
  logic            w_s_mulhsu;
  logic            w_s_div;
  logic            w_s_sdiv;
  logic            w_s_neg_b;
  logic            w_s_neg_a;
  logic            w_s_neg_res;
  logic            w_s_div0;
  logic            w_s_ovf;
  logic [XLEN-1:0] w_s_special;

  logic [XLEN-1:0] w_r;
  logic            w_div_take;
  logic [XLEN-1:0] w_mul_s;
  logic            w_mul_c;
  logic [XLEN-1:0] w_word;
  logic            w_fix_neg_div;
  logic [XLEN-1:0] w_fix;

  // Operand sign handling is decided once at start from the incoming funct3.
  assign w_s_mulh    = (funct3_i == 3'b001);
  assign w_s_mulhsu  = (funct3_i == 3'b010);
  assign w_s_div     = funct3_i[2];
  assign w_s_sdiv    = funct3_i[2] & ~funct3_i[0];
  assign w_s_neg_b   = (w_s_mulh | w_s_mulhsu | w_s_sdiv) & op1_i[XLEN-1];
  assign w_s_neg_a   = (w_s_mulh | w_s_sdiv) & op2_i[XLEN-1];
  assign w_s_neg_res = (funct3_i == 3'b110) ? w_s_neg_b :
                       (w_s_mulh | w_s_mulhsu | (funct3_i == 3'b100)) ? (w_s_neg_a ^ w_s_neg_b) :
                       1'b0;
  assign w_s_div0    = w_s_div & (op2_i == '0);
  assign w_s_ovf     = w_s_sdiv & (op1_i == MIN_INT) & (op2_i == '1);
  assign w_s_special = w_s_div0 ? (funct3_i[1] ? op1_i : '1) :
                                  (funct3_i[1] ? '0 : op1_i);

  // M (ACC[63]) marks a 65-bit partial remainder that always exceeds the divisor.
  assign w_r        = {r_acc[XLEN-2:0], r_b[XLEN-1]};
  assign w_div_take = r_acc[XLEN-1] | (w_r >= r_a);
  assign w_mul_s    = r_b[0] ? alu_result_i : r_acc;
  assign w_mul_c    = r_b[0] & (alu_result_i < r_acc);

  assign w_word        = ((r_op == 3'b000) || (r_op[2:1] == 2'b10)) ? r_b : r_acc;
  assign w_fix_neg_div = r_neg_res & r_op[2];
  assign w_fix         = (r_neg_res & ~r_op[2]) ? (~r_acc + {{(XLEN-1){1'b0}}, (r_b == '0)}) :
                         w_fix_neg_div ? alu_result_i : w_word;

  always_comb begin
    alu_op1_o    = '0;
    alu_op2_o    = '0;
    alu_op_sel_o = ALU_NONE;
    case (r_state)
      S_NEGB: begin
        alu_op_sel_o = r_neg_b ? ALU_SUB : ALU_ADD;
        alu_op2_o    = r_neg_b ? r_b : '0;
      end
      S_NEGA: begin
        alu_op_sel_o = r_neg_a ? ALU_SUB : ALU_ADD;
        alu_op2_o    = r_neg_a ? r_a : '0;
      end
      S_ITER: begin
        alu_op1_o    = r_op[2] ? w_r : r_acc;
        alu_op2_o    = r_a;
        alu_op_sel_o = r_op[2] ? ALU_SUB : ALU_ADD;
      end
      S_FIX: begin
        alu_op2_o    = w_fix_neg_div ? w_word : '0;
        alu_op_sel_o = w_fix_neg_div ? ALU_SUB : ALU_ADD;
      end
      default: begin
        alu_op1_o    = '0;
        alu_op2_o    = '0;
        alu_op_sel_o = ALU_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else if (kill_i && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_op      <= funct3_i;
            r_a       <= op2_i;
            r_b       <= op1_i;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_b   <= w_s_neg_b;
            r_neg_a   <= w_s_neg_a;
            r_neg_res <= w_s_neg_res;
            r_busy    <= 1'b1;
            if (w_s_div0 || w_s_ovf) begin
              r_result <= w_s_special;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_NEGB;
            end
          end
        end
        S_NEGB: begin
          if (r_neg_b) r_b <= alu_result_i;
          r_state <= S_NEGA;
        end
        S_NEGA: begin
          if (r_neg_a) r_a <= alu_result_i;
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (r_op[2]) begin
            r_acc <= w_div_take ? alu_result_i : w_r;
            r_b   <= {r_b[XLEN-2:0], w_div_take};
          end else begin
            r_acc <= {w_mul_c, w_mul_s[XLEN-1:1]};
            r_b   <= {w_mul_s[0], r_b[XLEN-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Randomized bench for rv_muldiv_seq with a plain-arithmetic RV64M reference model
// and a behavioural shared ALU answering the sequencer's requests.
module tb_rv_muldiv_seq;

  localparam logic [63:0] MIN_INT  = 64'h8000_0000_0000_0000;
  localparam logic [3:0]  SEL_ADD  = 4'b0010;
  localparam logic [3:0]  SEL_SUB  = 4'b0110;
  localparam int          MAX_WAIT = 100;

  logic        clk;
  logic        rstN;
  logic        startIn;
  logic        killIn;
  logic [2:0]  funct3In;
  logic [63:0] op1In;
  logic [63:0] op2In;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [63:0] aluOp1;
  logic [63:0] aluOp2;
  logic [3:0]  aluSel;
  logic [63:0] aluResult;

  int          checkCount;
  int          errorCount;
  logic [63:0] lastExpected;

  rv_muldiv_seq #(.XLEN(64)) dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .start_i      (startIn),
    .kill_i       (killIn),
    .funct3_i     (funct3In),
    .op1_i        (op1In),
    .op2_i        (op2In),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result),
    .alu_op1_o    (aluOp1),
    .alu_op2_o    (aluOp2),
    .alu_op_sel_o (aluSel),
    .alu_result_i (aluResult)
  );

  // Shared execute-stage ALU as the sequencer sees it.
  assign aluResult = (aluSel == SEL_ADD) ? aluOp1 + aluOp2 :
                     (aluSel == SEL_SUB) ? aluOp1 - aluOp2 : 64'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%h required 0x%h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, za, zb, p;
    longint       qa, qb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    za = {64'd0, a};
    zb = {64'd0, b};
    qa = $signed(a);
    qb = $signed(b);
    p  = '0;
    case (f3)
      3'b000: begin p = za * zb; return p[63:0];   end
      3'b001: begin p = sa * sb; return p[127:64]; end
      3'b010: begin p = sa * zb; return p[127:64]; end
      3'b011: begin p = za * zb; return p[127:64]; end
      3'b100: begin
        if (b == 64'd0) return '1;
        if (a == MIN_INT && b == '1) return a;
        return $unsigned(qa / qb);
      end
      3'b101: return (b == 64'd0) ? '1 : a / b;
      3'b110: begin
        if (b == 64'd0) return a;
        if (a == MIN_INT && b == '1) return 64'd0;
        return $unsigned(qa % qb);
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    return f3[2] && ((b == 64'd0) || (!f3[0] && a == MIN_INT && b == '1));
  endfunction

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 7))
      0, 1, 2: return {$urandom(), $urandom()};
      3:       return 64'($urandom_range(0, 20));
      4:       return 64'd0 - 64'($urandom_range(1, 20));
      5:       return 64'd0;
      6:       return MIN_INT;
      default: return '1;
    endcase
  endfunction

  // Runs one operation from the current cycle, optionally poking a stray start
  // mid-operation (pokeCycle) or in the done cycle (pokeDone), and checks it.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [63:0] a,
                               input logic [63:0] b, input int pokeCycle, input bit pokeDone);
    logic [63:0] expected;
    int          expLatency;
    logic [3:0]  expSel;
    int          cycle;
    int          busyBad;
    int          heldBad;
    int          selBad;
    int          extraBad;
    expected   = refModel(f3, a, b);
    expLatency = isSpecial(f3, a, b) ? 1 : 68;
    expSel     = f3[2] ? SEL_SUB : SEL_ADD;
    busyBad    = 0;
    heldBad    = 0;
    selBad     = 0;
    extraBad   = 0;
    funct3In   = f3;
    op1In      = a;
    op2In      = b;
    startIn    = 1'b1;
    @(posedge clk);
    #1;
    cycle = 1;
    while (1) begin
      if (!busy) busyBad++;
      if (done || cycle >= MAX_WAIT) break;
      if (result !== lastExpected) heldBad++;
      if (cycle >= 3 && cycle <= 66 && aluSel !== expSel) selBad++;
      startIn = (cycle == pokeCycle);
      if (cycle == pokeCycle) begin
        funct3In = ~f3;
        op1In    = 64'd5;
        op2In    = 64'd9;
      end
      @(posedge clk);
      #1;
      cycle++;
    end
    checkOutput({tag, ".latency"}, 64'(cycle), 64'(expLatency));
    checkOutput({tag, ".result"}, result, expected);
    checkOutput({tag, ".busy"}, 64'(busyBad), 64'd0);
    checkOutput({tag, ".held"}, 64'(heldBad), 64'd0);
    if (expLatency == 68) checkOutput({tag, ".itersel"}, 64'(selBad), 64'd0);
    startIn = pokeDone;
    if (pokeDone) begin
      funct3In = 3'b000;
      op1In    = 64'd3;
      op2In    = 64'd4;
    end
    @(posedge clk);
    #1;
    startIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (busy || done || result !== expected) extraBad++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, ".idleafter"}, 64'(extraBad), 64'd0);
    lastExpected = expected;
  endtask

  initial begin
    int          sawDone;
    logic [2:0]  rf3;
    logic [63:0] ra;
    logic [63:0] rb;
    checkCount   = 0;
    errorCount   = 0;
    lastExpected = 64'd0;
    rstN         = 1'b0;
    startIn      = 1'b0;
    killIn       = 1'b0;
    funct3In     = 3'b000;
    op1In        = 64'd0;
    op2In        = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.result", result, 64'd0);
    checkOutput("reset.aluop1", aluOp1, 64'd0);
    checkOutput("reset.aluop2", aluOp2, 64'd0);
    checkOutput("reset.alusel", 64'(aluSel), 64'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("mul7x6", 3'b000, 64'd7, 64'd6, 0, 1'b0);
    applyStimulus("mulhu", 3'b011, '1, '1, 0, 1'b0);
    applyStimulus("mulh", 3'b001, 64'd0 - 64'd2, 64'd3, 0, 1'b0);
    applyStimulus("div", 3'b100, 64'd0 - 64'd7, 64'd2, 10, 1'b1);
    applyStimulus("rem", 3'b110, 64'd0 - 64'd7, 64'd2, 0, 1'b0);
    applyStimulus("divu", 3'b101, 64'd100, 64'd7, 0, 1'b0);
    applyStimulus("remu", 3'b111, 64'd100, 64'd7, 0, 1'b0);
    applyStimulus("divu0", 3'b101, 64'd1234, 64'd0, 0, 1'b0);
    applyStimulus("removf", 3'b110, MIN_INT, '1, 0, 1'b0);

    // Flush partway through a divide, then restart on the very next cycle.
    sawDone  = 0;
    funct3In = 3'b101;
    op1In    = 64'd1000;
    op2In    = 64'd3;
    startIn  = 1'b1;
    @(posedge clk);
    #1;
    startIn = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (done) sawDone++;
      @(posedge clk);
      #1;
    end
    killIn = 1'b1;
    if (done) sawDone++;
    @(posedge clk);
    #1;
    killIn = 1'b0;
    checkOutput("kill.busy", 64'(busy), 64'd0);
    checkOutput("kill.alusel", 64'(aluSel), 64'd0);
    checkOutput("kill.done", 64'(sawDone + int'(done)), 64'd0);
    checkOutput("kill.result", result, lastExpected);
    applyStimulus("afterkill", 3'b001, 64'd0 - 64'd12345, 64'd987654321, 0, 1'b0);

    // Asynchronous reset in the middle of an operation.
    funct3In = 3'b100;
    op1In    = 64'd77777;
    op2In    = 64'd0 - 64'd13;
    startIn  = 1'b1;
    @(posedge clk);
    #1;
    startIn = 1'b0;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk);
      #1;
    end
    rstN = 1'b0;
    #1;
    checkOutput("midreset.busy", 64'(busy), 64'd0);
    checkOutput("midreset.alusel", 64'(aluSel), 64'd0);
    checkOutput("midreset.done", 64'(done), 64'd0);
    checkOutput("midreset.result", result, 64'd0);
    @(posedge clk);
    #1;
    rstN         = 1'b1;
    lastExpected = 64'd0;
    applyStimulus("afterreset", 3'b110, 64'd77777, 64'd0 - 64'd13, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = randOperand();
      rb  = randOperand();
      applyStimulus($sformatf("rand%0d_f%0d", n, rf3), rf3, ra, rb, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
